// File: rtl/shift_rotate_arbiter_pkg.sv
// Shared definitions for the shift/rotate arbiter block.
// Contains the width constants, the op codes, the request/response
// structs carried through the arbiter, and the op legality check.
package shift_rotate_pkg;

  localparam int DATA_W = 32;
  localparam int AMT_W  = 5;

  localparam logic [2:0] OP_ROL  = 3'd0;
  localparam logic [2:0] OP_ROR  = 3'd1;
  localparam logic [2:0] OP_SHL  = 3'd2;
  localparam logic [2:0] OP_SHR  = 3'd3;
  localparam logic [2:0] OP_SHRA = 3'd4;

  typedef struct packed {
    logic [2:0]        op;
    logic [DATA_W-1:0] data;
    logic [AMT_W-1:0]  amt;
  } sr_req_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              id;
    logic              err;
  } sr_resp_t;

  // Codes 5..7 are reserved and come back unchanged with err set.
  function automatic logic is_legal_op(input logic [2:0] op);
    return (op <= OP_SHRA);
  endfunction

endpackage

// File: rtl/shift_rotate_arbiter_if.sv
// Handshake bundle for the shift/rotate arbiter.
//   req0_* / req1_* : two requester ports (valid/ready + op, data, amt)
//   resp_*          : one registered response port (valid/ready + data, id, err)
// master = requesters and response consumer, slave = the arbiter.
interface shift_rotate_arbiter_if;
  import shift_rotate_pkg::*;

  logic              req0_valid;
  logic              req0_ready;
  logic [2:0]        req0_op;
  logic [DATA_W-1:0] req0_data;
  logic [AMT_W-1:0]  req0_amt;

  logic              req1_valid;
  logic              req1_ready;
  logic [2:0]        req1_op;
  logic [DATA_W-1:0] req1_data;
  logic [AMT_W-1:0]  req1_amt;

  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic              resp_id;
  logic              resp_err;

  modport master (
    output req0_valid, req0_op, req0_data, req0_amt,
    input  req0_ready,
    output req1_valid, req1_op, req1_data, req1_amt,
    input  req1_ready,
    input  resp_valid, resp_data, resp_id, resp_err,
    output resp_ready
  );

  modport slave (
    input  req0_valid, req0_op, req0_data, req0_amt,
    output req0_ready,
    input  req1_valid, req1_op, req1_data, req1_amt,
    output req1_ready,
    output resp_valid, resp_data, resp_id, resp_err,
    input  resp_ready
  );

endinterface

// File: rtl/shift_rotate_arbiter_rotate_mask_unit.sv
// Combinational shift/rotate datapath.
//   op, data, amt -> result, err
// Every op is a left rotate followed by masking/fill: right rotates
// use the complementary left amount (-amt mod 32), logical shifts
// clear the wrapped-in bits, and SHRA sets them from the sign bit.
module rotate_mask_unit
  import shift_rotate_pkg::*;
(
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] data,
  input  logic [AMT_W-1:0]  amt,
  output logic [DATA_W-1:0] result,
  output logic              err
);

  logic [AMT_W-1:0]  amt_neg;
  logic [AMT_W-1:0]  rot_amt;
  logic [AMT_W:0]    rot_inv;
  logic [DATA_W-1:0] rot;
  logic [DATA_W-1:0] mask_l;
  logic [DATA_W-1:0] mask_r;

  assign amt_neg = -amt;
  assign rot_amt = (op == OP_ROL || op == OP_SHL) ? amt : amt_neg;
  // rot_inv reaches DATA_W when rot_amt is 0; that right shift yields 0,
  // so the zero-amount rotate degenerates cleanly to data.
  assign rot_inv = (AMT_W+1)'(DATA_W) - {1'b0, rot_amt};
  assign rot     = (data << rot_amt) | (data >> rot_inv);

  assign mask_l  = {DATA_W{1'b1}} << amt;
  assign mask_r  = {DATA_W{1'b1}} >> amt;

  always_comb begin
    result = data;
    err    = 1'b0;
    case (op)
      OP_ROL:  result = rot;
      OP_ROR:  result = rot;
      OP_SHL:  result = rot & mask_l;
      OP_SHR:  result = rot & mask_r;
      OP_SHRA: result = (rot & mask_r) | (data[DATA_W-1] ? ~mask_r : '0);
      default: begin
        result = data;
        err    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/shift_rotate_arbiter.sv
// Two-requester round-robin front end to a shared shift/rotate unit,
// with a one-entry registered result buffer.
//   clk  : rising-edge clock
//   clr  : asynchronous active-high reset
//   bus  : slave side of shift_rotate_arbiter_if (two request ports,
//          one response port)
// A granted op is computed in the same cycle and captured at the edge;
// the result is visible the following cycle. A new op is accepted
// whenever the buffer is empty or is being drained this cycle.
module shift_rotate_arbiter
  import shift_rotate_pkg::*;
#(
  parameter int DATA_W_P = DATA_W
) (
  input  logic clk,
  input  logic clr,
  shift_rotate_arbiter_if.slave bus
);

  if (DATA_W_P != 32) begin : g_width_check
    $error("shift_rotate_arbiter: only DATA_W = 32 is supported");
  end

  logic     ptr_q, ptr_d;           // requester holding priority on a tie
  logic     resp_valid_q, resp_valid_d;
  sr_resp_t resp_q, resp_d;

  logic     buf_free;
  logic     grant0, grant1, grant_any;
  sr_req_t  req0, req1, req_sel;
  logic [DATA_W-1:0] unit_result;
  logic     unit_err;

  assign req0 = '{op: bus.req0_op, data: bus.req0_data, amt: bus.req0_amt};
  assign req1 = '{op: bus.req1_op, data: bus.req1_data, amt: bus.req1_amt};

  assign buf_free  = !resp_valid_q || bus.resp_ready;
  // clr gates grants so neither ready can rise while reset is held.
  assign grant0    = !clr && buf_free && bus.req0_valid && (!bus.req1_valid || !ptr_q);
  assign grant1    = !clr && buf_free && bus.req1_valid && (!bus.req0_valid ||  ptr_q);
  assign grant_any = grant0 || grant1;
  assign req_sel   = grant1 ? req1 : req0;

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  rotate_mask_unit u_unit (
    .op     (req_sel.op),
    .data   (req_sel.data),
    .amt    (req_sel.amt),
    .result (unit_result),
    .err    (unit_err)
  );

  always_comb begin
    ptr_d        = ptr_q;
    resp_valid_d = resp_valid_q;
    resp_d       = resp_q;
    if (grant_any) begin
      // Load wins over drain: an accepted op replaces the leaving result.
      ptr_d        = !grant1;
      resp_valid_d = 1'b1;
      resp_d       = '{data: unit_result, id: grant1, err: unit_err};
    end else if (bus.resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ptr_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_q       <= '0;
    end else begin
      ptr_q        <= ptr_d;
      resp_valid_q <= resp_valid_d;
      resp_q       <= resp_d;
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_q.data;
  assign bus.resp_id    = resp_q.id;
  assign bus.resp_err   = resp_q.err;

endmodule

// File: tb/tb_shift_rotate_arbiter.sv
// Directed self-checking bench for shift_rotate_arbiter.
// Inputs change on the falling edge; readies are sampled 1ns later,
// registered outputs 1ns after the rising edge.
module tb_shift_rotate_arbiter;
  logic clk = 1'b0;
  logic clr = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  shift_rotate_arbiter_if sr_if ();

  shift_rotate_arbiter dut (
    .clk (clk),
    .clr (clr),
    .bus (sr_if.slave)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    sr_if.req0_valid = 1'b0; sr_if.req0_op = 3'd0; sr_if.req0_data = '0; sr_if.req0_amt = '0;
    sr_if.req1_valid = 1'b0; sr_if.req1_op = 3'd0; sr_if.req1_data = '0; sr_if.req1_amt = '0;
    sr_if.resp_ready = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    sr_if.req0_valid = 1'b1;
    sr_if.req1_valid = 1'b1;
    #3;
    n_cmp++; if (sr_if.resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", sr_if.resp_valid); end
    n_cmp++; if (sr_if.resp_data !== 32'h0) begin n_bad++; $display("FAIL reset_data got %h want 00000000", sr_if.resp_data); end
    n_cmp++; if (sr_if.resp_id !== 1'b0 || sr_if.resp_err !== 1'b0) begin n_bad++; $display("FAIL reset_id_err got %b%b want 00", sr_if.resp_id, sr_if.resp_err); end
    n_cmp++; if (sr_if.req0_ready !== 1'b0 || sr_if.req1_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready got %b%b want 00", sr_if.req0_ready, sr_if.req1_ready); end
    @(negedge clk);
    idle_inputs();
    clr = 1'b0;
  endtask

  task automatic test_ops();
    logic [2:0]  op_t  [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    logic [31:0] dat_t [5] = '{32'h80000001, 32'h00000001, 32'h0000000F, 32'h80000000, 32'h80000000};
    logic [4:0]  amt_t [5] = '{5'd1, 5'd4, 5'd28, 5'd4, 5'd4};
    logic [31:0] exp_t [5] = '{32'h00000003, 32'h10000000, 32'hF0000000, 32'h08000000, 32'hF8000000};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      sr_if.req0_valid = 1'b1; sr_if.req0_op = op_t[i]; sr_if.req0_data = dat_t[i]; sr_if.req0_amt = amt_t[i];
      #1;
      n_cmp++; if (sr_if.req0_ready !== 1'b1) begin n_bad++; $display("FAIL ops[%0d] req0_ready got %b want 1", i, sr_if.req0_ready); end
      @(posedge clk); #1;
      sr_if.req0_valid = 1'b0;
      n_cmp++; if (sr_if.resp_valid !== 1'b1) begin n_bad++; $display("FAIL ops[%0d] resp_valid got %b want 1", i, sr_if.resp_valid); end
      n_cmp++; if (sr_if.resp_data !== exp_t[i]) begin n_bad++; $display("FAIL ops[%0d] resp_data got %h want %h", i, sr_if.resp_data, exp_t[i]); end
      n_cmp++; if (sr_if.resp_id !== 1'b0 || sr_if.resp_err !== 1'b0) begin n_bad++; $display("FAIL ops[%0d] id_err got %b%b want 00", i, sr_if.resp_id, sr_if.resp_err); end
    end
    @(negedge clk);
  endtask

  task automatic test_edges();
    logic        rq_t  [12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  op_t  [12] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7, 3'd5, 3'd1, 3'd4, 3'd4, 3'd3, 3'd2};
    logic [31:0] dat_t [12] = '{32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF,
                                32'h12345678, 32'h12345678, 32'h00000001, 32'h80000000, 32'h7FFFFFFF,
                                32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [4:0]  amt_t [12] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd3, 5'd9, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31};
    logic [31:0] exp_t [12] = '{32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF,
                                32'h12345678, 32'h12345678, 32'h00000002, 32'hFFFFFFFF, 32'h00000000,
                                32'h00000001, 32'h80000000};
    logic        err_t [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rq_t[i]) begin
        sr_if.req1_valid = 1'b1; sr_if.req1_op = op_t[i]; sr_if.req1_data = dat_t[i]; sr_if.req1_amt = amt_t[i];
      end else begin
        sr_if.req0_valid = 1'b1; sr_if.req0_op = op_t[i]; sr_if.req0_data = dat_t[i]; sr_if.req0_amt = amt_t[i];
      end
      @(posedge clk); #1;
      sr_if.req0_valid = 1'b0; sr_if.req1_valid = 1'b0;
      n_cmp++; if (sr_if.resp_data !== exp_t[i]) begin n_bad++; $display("FAIL edge[%0d] resp_data got %h want %h", i, sr_if.resp_data, exp_t[i]); end
      n_cmp++; if (sr_if.resp_err !== err_t[i]) begin n_bad++; $display("FAIL edge[%0d] resp_err got %b want %b", i, sr_if.resp_err, err_t[i]); end
      n_cmp++; if (sr_if.resp_id !== rq_t[i]) begin n_bad++; $display("FAIL edge[%0d] resp_id got %b want %b", i, sr_if.resp_id, rq_t[i]); end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    sr_if.resp_ready = 1'b0;
    sr_if.req1_valid = 1'b1; sr_if.req1_op = 3'd0; sr_if.req1_data = 32'hA5A5A5A5; sr_if.req1_amt = 5'd0;
    @(posedge clk); #1;
    sr_if.req1_valid = 1'b0;
    n_cmp++; if (sr_if.resp_valid !== 1'b1 || sr_if.resp_id !== 1'b1) begin n_bad++; $display("FAIL midrst_pre got v=%b id=%b want v=1 id=1", sr_if.resp_valid, sr_if.resp_id); end
    @(negedge clk); #2;
    clr = 1'b1;
    sr_if.req0_valid = 1'b1; sr_if.req1_valid = 1'b1; sr_if.resp_ready = 1'b1;
    #1;
    n_cmp++; if (sr_if.resp_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid got %b want 0", sr_if.resp_valid); end
    n_cmp++; if (sr_if.resp_data !== 32'h0 || sr_if.resp_id !== 1'b0) begin n_bad++; $display("FAIL midrst_data got %h/%b want 00000000/0", sr_if.resp_data, sr_if.resp_id); end
    n_cmp++; if (sr_if.req0_ready !== 1'b0 || sr_if.req1_ready !== 1'b0) begin n_bad++; $display("FAIL midrst_ready got %b%b want 00", sr_if.req0_ready, sr_if.req1_ready); end
    @(posedge clk); #1;
    n_cmp++; if (sr_if.resp_valid !== 1'b0 || sr_if.req0_ready !== 1'b0) begin n_bad++; $display("FAIL midrst_held got v=%b r0=%b want 0 0", sr_if.resp_valid, sr_if.req0_ready); end
    @(negedge clk);
    idle_inputs();
    clr = 1'b0;
  endtask

  task automatic test_contention();
    logic [31:0] exp_d;
    sr_if.req0_op = 3'd0; sr_if.req0_data = 32'h0000AAAA; sr_if.req0_amt = 5'd0;
    sr_if.req1_op = 3'd0; sr_if.req1_data = 32'h0000BBBB; sr_if.req1_amt = 5'd0;
    sr_if.req0_valid = 1'b1; sr_if.req1_valid = 1'b1; sr_if.resp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_cmp++; if (sr_if.req0_ready !== (i % 2 == 0) || sr_if.req1_ready !== (i % 2 == 1)) begin
        n_bad++; $display("FAIL cont[%0d] ready got %b%b want one-hot grant %0d", i, sr_if.req1_ready, sr_if.req0_ready, i % 2);
      end
      exp_d = (i % 2 == 0) ? 32'h0000AAAA : 32'h0000BBBB;
      @(posedge clk); #1;
      n_cmp++; if (sr_if.resp_id !== 1'(i % 2) || sr_if.resp_data !== exp_d) begin
        n_bad++; $display("FAIL cont[%0d] resp got id=%b %h want id=%0d %h", i, sr_if.resp_id, sr_if.resp_data, i % 2, exp_d);
      end
      @(negedge clk);
    end
    sr_if.req0_valid = 1'b0; sr_if.req1_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    sr_if.resp_ready = 1'b0;
    sr_if.req0_valid = 1'b1; sr_if.req0_op = 3'd2; sr_if.req0_data = 32'h00000001; sr_if.req0_amt = 5'd8;
    @(posedge clk); #1;
    sr_if.req0_op = 3'd3; sr_if.req0_data = 32'h00000100; sr_if.req0_amt = 5'd4;
    sr_if.req1_valid = 1'b1; sr_if.req1_op = 3'd1; sr_if.req1_data = 32'h00000001; sr_if.req1_amt = 5'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      n_cmp++; if (sr_if.req0_ready !== 1'b0 || sr_if.req1_ready !== 1'b0) begin n_bad++; $display("FAIL bp[%0d] ready got %b%b want 00", i, sr_if.req1_ready, sr_if.req0_ready); end
      n_cmp++; if (sr_if.resp_valid !== 1'b1 || sr_if.resp_data !== 32'h00000100 || sr_if.resp_id !== 1'b0) begin
        n_bad++; $display("FAIL bp[%0d] held got v=%b %h id=%b want v=1 00000100 id=0", i, sr_if.resp_valid, sr_if.resp_data, sr_if.resp_id);
      end
    end
    @(negedge clk);
    sr_if.resp_ready = 1'b1;
    #1;
    n_cmp++; if (sr_if.req1_ready !== 1'b1 || sr_if.req0_ready !== 1'b0) begin n_bad++; $display("FAIL bp_release ready got %b%b want 10", sr_if.req1_ready, sr_if.req0_ready); end
    @(posedge clk); #1;
    sr_if.req0_valid = 1'b0; sr_if.req1_valid = 1'b0;
    n_cmp++; if (sr_if.resp_valid !== 1'b1 || sr_if.resp_data !== 32'h80000000 || sr_if.resp_id !== 1'b1) begin
      n_bad++; $display("FAIL bp_swap got v=%b %h id=%b want v=1 80000000 id=1", sr_if.resp_valid, sr_if.resp_data, sr_if.resp_id);
    end
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (sr_if.resp_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drain resp_valid got %b want 0", sr_if.resp_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_t [8] = '{32'h10, 32'h20, 32'h30, 32'h40, 32'h50, 32'h60, 32'h70, 32'h80};
    sr_if.resp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sr_if.req1_valid = 1'b1; sr_if.req1_op = 3'd2; sr_if.req1_data = 32'(i + 1); sr_if.req1_amt = 5'd4;
      #1;
      n_cmp++; if (sr_if.req1_ready !== 1'b1) begin n_bad++; $display("FAIL b2b[%0d] req1_ready got %b want 1", i, sr_if.req1_ready); end
      @(posedge clk); #1;
      n_cmp++; if (sr_if.resp_valid !== 1'b1 || sr_if.resp_data !== exp_t[i] || sr_if.resp_id !== 1'b1) begin
        n_bad++; $display("FAIL b2b[%0d] got v=%b %h id=%b want v=1 %h id=1", i, sr_if.resp_valid, sr_if.resp_data, sr_if.resp_id, exp_t[i]);
      end
      @(negedge clk);
    end
    sr_if.req1_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_ops();
    test_edges();
    test_reset_mid();
    test_contention();
    test_backpressure();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/shift_rotate_arbiter.md
Name: shift_rotate_arbiter

Overview:
- Shares one 32-bit shift/rotate datapath between two requesters, e.g. the ALU issue path and the address/immediate formatting path.
- Supports ROL, ROR, SHL, SHR and SHRA; all five are derived from a single rotate-left core plus fill masking.
- Round-robin arbitration between the two requesters.
- One-entry registered result buffer with a valid/ready handshake on both the request side and the response side.

Parameters:
- DATA_W, 32: operand/result width. Only 32 is supported; elaboration error otherwise.
- AMT_W, 5: shift-amount width, equal to log2(DATA_W).

Ports:
- clk  in  1  rising-edge clock.
- clr  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 presents an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_op  in  3  operation code (see package).
- req0_data  in  32  operand.
- req0_amt  in  5  shift/rotate amount, 0..31.
- req1_valid / req1_ready / req1_op / req1_data / req1_amt: same as requester 0, for requester 1.
- resp_valid  out  1  result buffer holds a result.
- resp_ready  in  1  consumer takes the result this cycle.
- resp_data  out  32  result.
- resp_id  out  1  which requester produced the result.
- resp_err  out  1  the op was illegal; resp_data = operand unchanged.

Behaviour:
- Reset (clr=1, asynchronous):
  - resp_valid=0, resp_data=0, resp_id=0, resp_err=0.
  - Priority pointer = requester 0.
  - req0_ready and req1_ready are 0 while clr is high.
- Buffer free condition: buf_free = !resp_valid || resp_ready. No new request is granted unless buf_free.
- Arbitration (combinational, same cycle):
  - If buf_free and exactly one reqN_valid is high, grant N.
  - If both are high, grant the requester named by the pointer.
  - reqN_ready = grant_N. At most one ready is high per cycle.
  - A requester is never readied without valid.
- Pointer update: on any grant, the pointer moves to the other requester. With no grant the pointer holds. Strict alternation under continuous contention.
- Latency and throughput:
  - A granted op is computed combinationally and captured at the same rising edge.
  - resp_valid=1 from the next cycle: 1-cycle latency.
  - Full throughput (one op per cycle) while resp_ready=1.
- Response hold: while resp_valid=1 and resp_ready=0, resp_data, resp_id and resp_err are held stable.
- Simultaneous drain and accept: the old result leaves and the new result loads at the same edge; resp_valid stays 1.
- Op encoding:
  - 0 ROL: rotl(d,n).
  - 1 ROR: rotl(d,(32-n) mod 32).
  - 2 SHL: rotl(d,n) AND (0xFFFFFFFF << n).
  - 3 SHR: rotl(d,(32-n) mod 32) AND (0xFFFFFFFF >> n).
  - 4 SHRA: as SHR, then OR with NOT(0xFFFFFFFF >> n) when d[31]=1.
  - 5..7 illegal: result = d, resp_err=1.
  - resp_err=0 for all legal ops.
- Amount 0: every legal op returns d unchanged.
- Amount width: arithmetic is modulo 32 on AMT_W bits; no amount ≥32 exists.
- Reset mid-operation: an in-flight buffered result is discarded and resp_valid drops immediately. Requesters must re-present their op.
- No state machine beyond the pointer bit and the buffer-valid bit.

Decomposition:
- Shared package `shift_rotate_pkg`:
  - Op codes OP_ROL=3'd0, OP_ROR=3'd1, OP_SHL=3'd2, OP_SHR=3'd3, OP_SHRA=3'd4.
  - DATA_W and AMT_W constants.
  - Function is_legal_op.
- Sub-module `rotate_mask_unit`: purely combinational.
  - Inputs: op, data, amt. Outputs: result, err.
  - Holds the rotate-left core and the mask/fill generation.
- Top level holds the arbiter, pointer and result buffer.

Test Plan:
- Reset values: assert clr mid-run with resp_valid=1 → resp_valid=0, resp_data=0, resp_id=0 asynchronously; no ready asserted while clr=1.
- Single requester, all ops, resp_ready=1. Response one cycle after the grant, resp_id=0, resp_err=0:
  - req0 ROL 0x80000001 by 1 → 0x00000003.
  - ROR 0x00000001 by 4 → 0x10000000.
  - SHL 0x0000000F by 28 → 0xF0000000.
  - SHR 0x80000000 by 4 → 0x08000000.
  - SHRA 0x80000000 by 4 → 0xF8000000.
- Amount/illegal edge cases:
  - Any legal op with amt=0 on 0xDEADBEEF → 0xDEADBEEF.
  - op=7 with data 0x12345678 → 0x12345678 and resp_err=1.
- Contention: both valid every cycle, resp_ready=1 → grants 0,1,0,1…; resp_id sequence alternates; no cycle with both readys high.
- Backpressure: grant one op, then hold resp_ready=0 for 5 cycles → both req_ready=0 and resp_data stable for 5 cycles. Raise resp_ready → the pending op is accepted in that same cycle; resp_valid stays 1.
- Full throughput: resp_ready=1 and req1 valid for 8 consecutive ops → 8 results on 8 consecutive cycles, in order, all resp_id=1.
